// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants, transmitter state type and elaboration-time helpers
// for the FIFO-fed UART transmitter.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Nearest-integer clocks per bit.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO whose read port presents the current head word from a
// register, so a consumer can take it on the same edge that it pops.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;
  logic             w_head_from_wr;
  logic [AW-1:0]    w_rd_ptr_inc;

  assign o_full       = (r_level == FULL_LEVEL);
  assign o_empty      = (r_level == '0);
  assign w_push       = i_push && !o_full;
  assign w_pop        = i_pop && !o_empty;
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;
  // The incoming word becomes the head when no older word survives this edge.
  assign w_head_from_wr = w_push && (o_empty || (w_pop && r_level == ONE_LEVEL));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    if (w_head_from_wr) r_head <= i_wr_data;
    else if (w_pop)     r_head <= r_mem[w_rd_ptr_inc];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rd_data = r_head;
  assign o_level   = r_level;
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with clock-enable baud timing and an input FIFO; frames are
// start, DATA_BITS LSB first, optional parity, then STOP_BITS high bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int  CLK_HZ    = 12000000,
  parameter int  BAUD      = 9600,
  parameter int  DATA_BITS = 8,
  parameter int  PARITY    = 0,
  parameter int  STOP_BITS = 1,
  parameter int  DEPTH     = 4,
  localparam int LW        = clog2(DEPTH) + 1
) (
  input  logic                 hw_clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [LW-1:0]        fifo_level
);
  localparam int            DIV       = baud_div(CLK_HZ, BAUD);
  localparam int            CW        = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam int            BW        = clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: baud divisor must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two, at least 2");
  end

  tx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_frame_done;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic [LW-1:0]        w_level;
  logic                 w_tick;
  logic                 w_last_stop;
  logic                 w_pop;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (hw_clk),
    .rst_n    (rst_n),
    .i_push   (s_valid),
    .i_wr_data(s_data),
    .i_pop    (w_pop),
    .o_rd_data(w_head),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (w_level)
  );

  assign w_tick      = (r_state != TX_IDLE) && (r_cnt == CNT_LAST);
  assign w_last_stop = (r_state == TX_STOP) && (r_stop_idx == STOP_LAST);
  // Chaining the next pop onto the final stop tick gives gap-free frames.
  assign w_pop       = !w_empty && ((r_state == TX_IDLE) || (w_tick && w_last_stop));

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= TX_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= '0;
      r_stop_idx   <= 1'b0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_tx         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state != TX_IDLE) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        case (r_state)
          TX_START: begin
            r_state   <= TX_DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
          end
          TX_DATA: begin
            if (r_bit_idx == BIT_LAST) begin
              if (PARITY != PAR_NONE) begin
                r_state <= TX_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state    <= TX_STOP;
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
          TX_PARITY: begin
            r_state    <= TX_STOP;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
          end
          TX_STOP: begin
            if (w_last_stop) begin
              r_state      <= TX_IDLE;
              r_tx         <= 1'b1;
              r_frame_done <= 1'b1;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
          default: r_state <= TX_IDLE;
        endcase
      end
      if (w_pop) begin
        r_state <= TX_START;
        r_tx    <= 1'b0;
        r_cnt   <= '0;
        r_shift <= w_head;
        r_par   <= (^w_head) ^ PAR_INV;
      end
    end
  end

  assign s_ready    = !w_full;
  assign tx         = r_tx;
  assign busy       = (r_state != TX_IDLE) || !w_empty;
  assign frame_done = r_frame_done;
  assign fifo_level = w_level;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo over several frame formats,
// compared cycle by cycle against a frame-timeline model.
module tb_uart_tx_fifo;
  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sv   [NI];
  logic       rdy  [NI];
  logic       txw  [NI];
  logic       bz   [NI];
  logic       fd   [NI];
  logic [7:0] sd0, sd2, sd4;
  logic [6:0] sd1, sd3;
  logic [2:0] lvl0, lvl1, lvl3, lvl4;
  logic [1:0] lvl2;
  int         n_total = 0;
  int         n_bad   = 0;
  int         src_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) u_8n1 (
    .hw_clk(clk), .rst_n(rst_n), .s_data(sd0), .s_valid(sv[0]), .s_ready(rdy[0]),
    .tx(txw[0]), .busy(bz[0]), .frame_done(fd[0]), .fifo_level(lvl0));
  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) u_7e1 (
    .hw_clk(clk), .rst_n(rst_n), .s_data(sd1), .s_valid(sv[1]), .s_ready(rdy[1]),
    .tx(txw[1]), .busy(bz[1]), .frame_done(fd[1]), .fifo_level(lvl1));
  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DEPTH(2)) u_8o2 (
    .hw_clk(clk), .rst_n(rst_n), .s_data(sd2), .s_valid(sv[2]), .s_ready(rdy[2]),
    .tx(txw[2]), .busy(bz[2]), .frame_done(fd[2]), .fifo_level(lvl2));
  uart_tx_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) u_7o1 (
    .hw_clk(clk), .rst_n(rst_n), .s_data(sd3), .s_valid(sv[3]), .s_ready(rdy[3]),
    .tx(txw[3]), .busy(bz[3]), .frame_done(fd[3]), .fifo_level(lvl3));
  uart_tx_fifo u_dflt (
    .hw_clk(clk), .rst_n(rst_n), .s_data(sd4), .s_valid(sv[4]), .s_ready(rdy[4]),
    .tx(txw[4]), .busy(bz[4]), .frame_done(fd[4]), .fifo_level(lvl4));

  function automatic int div_of(int i);
    return (i == 4) ? 1250 : 16;
  endfunction
  function automatic int nb_of(int i);
    return (i == 1 || i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(int i);
    case (i)
      1:       return 2;
      2, 3:    return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int stop_of(int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int depth_of(int i);
    return (i == 2) ? 2 : 4;
  endfunction
  function automatic int frame_len(int i);
    return div_of(i) * (1 + nb_of(i) + ((par_of(i) != 0) ? 1 : 0) + stop_of(i));
  endfunction

  // Line level for bit slot k of a frame carrying data.
  function automatic int frame_bit(int i, int data, int k);
    int ones = 0;
    if (k == 0) return 0;
    if (k <= nb_of(i)) return (data >> (k - 1)) & 1;
    if (par_of(i) != 0 && k == nb_of(i) + 1) begin
      for (int b = 0; b < nb_of(i); b++) ones += (data >> b) & 1;
      return (par_of(i) == 2) ? (ones % 2) : (1 - ones % 2);
    end
    return 1;
  endfunction

  function automatic int get_lvl(int i);
    case (i)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      2:       return int'(lvl2);
      3:       return int'(lvl3);
      default: return int'(lvl4);
    endcase
  endfunction

  task automatic drive(input int i, input logic v, input int d);
    sv[i] = v;
    case (i)
      0:       sd0 = d[7:0];
      1:       sd1 = d[6:0];
      2:       sd2 = d[7:0];
      3:       sd3 = d[6:0];
      default: sd4 = d[7:0];
    endcase
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Offers src_q to instance i and checks every cycle against the model.
  task automatic run_case(input int i, input bit hold, input int stop_after,
                          output int o_low, output int o_done, output int o_gap, output int o_maxlvl);
    int    fq[$];
    int    fl = frame_len(i);
    int    cur_s = 0, cur_d = 0, prev_end = -1, d = 0, last_fd = -1, k, exp_tx;
    bit    have_cur = 1'b0, v = 1'b0, push, pop, fin = 1'b0;
    string pfx;
    o_low = 0; o_done = 0; o_gap = 0; o_maxlvl = 0;
    @(posedge clk); #1;
    if (src_q.size() > 0 && (hold || $urandom_range(0, 2) != 0)) begin
      v = 1'b1;
      d = src_q[0];
    end
    drive(i, v, d);
    for (int t = 0; t < 30000; t++) begin
      push = v && (fq.size() < depth_of(i));
      pop  = (fq.size() > 0) && (!have_cur || t >= cur_s + fl);
      if (pop) begin
        if (have_cur) prev_end = cur_s + fl;
        cur_d = fq.pop_front();
        cur_s = t;
        have_cur = 1'b1;
      end
      if (push) begin
        fq.push_back(src_q.pop_front());
        $display("push inst=%0d edge=%0d data=0x%02h", i, t, d);
      end
      @(posedge clk); #1;
      if (push || !v) begin
        v = (src_q.size() > 0) && (hold || $urandom_range(0, 2) != 0);
        d = v ? src_q[0] : int'($urandom_range(0, 127));
      end
      drive(i, v, d);
      @(negedge clk);
      k      = have_cur ? (t - cur_s) / div_of(i) : 0;
      exp_tx = (have_cur && t < cur_s + fl) ? frame_bit(i, cur_d, k) : 1;
      pfx    = $sformatf("i%0d_e%0d", i, t);
      chk({pfx, "_tx"},    int'(txw[i]), exp_tx);
      chk({pfx, "_done"},  int'(fd[i]), ((have_cur && t == cur_s + fl) || t == prev_end) ? 1 : 0);
      chk({pfx, "_busy"},  int'(bz[i]), ((have_cur && t < cur_s + fl) || fq.size() > 0) ? 1 : 0);
      chk({pfx, "_ready"}, int'(rdy[i]), (fq.size() < depth_of(i)) ? 1 : 0);
      chk({pfx, "_level"}, get_lvl(i), fq.size());
      if (txw[i] == 1'b0) o_low++;
      if (fd[i]) begin
        o_done++;
        if (last_fd >= 0) o_gap = t - last_fd;
        last_fd = t;
      end
      if (get_lvl(i) > o_maxlvl) o_maxlvl = get_lvl(i);
      if (stop_after > 0 && t == stop_after) break;
      fin = (src_q.size() == 0) && (fq.size() == 0) && (!have_cur || t > cur_s + fl);
      if (fin) break;
    end
    if (!fin && stop_after == 0) chk($sformatf("i%0d_timeout", i), 0, 1);
    drive(i, 1'b0, 0);
  endtask

  task automatic load_random(input int i, input int n);
    src_q.delete();
    for (int j = 0; j < n; j++) src_q.push_back(int'($urandom_range(0, (1 << nb_of(i)) - 1)));
  endtask

  initial begin
    int lo, dn, gp, ml;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) drive(i, 1'b0, 0);
    #12;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d_tx", i),    int'(txw[i]), 1);
      chk($sformatf("rst%0d_busy", i),  int'(bz[i]), 0);
      chk($sformatf("rst%0d_done", i),  int'(fd[i]), 0);
      chk($sformatf("rst%0d_ready", i), int'(rdy[i]), 1);
      chk($sformatf("rst%0d_level", i), get_lvl(i), 0);
    end
    #10 rst_n = 1'b1;

    src_q.delete(); src_q.push_back('h44);
    run_case(0, 1'b1, 0, lo, dn, gp, ml);
    chk("8n1_44_low_cycles", lo, 112);
    chk("8n1_44_done_cnt", dn, 1);

    src_q.delete();
    for (int j = 0; j < 6; j++) src_q.push_back('h41 + j);
    run_case(0, 1'b1, 0, lo, dn, gp, ml);
    chk("burst_done_cnt", dn, 6);
    chk("burst_max_level", ml, 4);
    chk("burst_done_gap", gp, 160);

    load_random(0, 8);
    run_case(0, 1'b0, 0, lo, dn, gp, ml);
    chk("8n1_rand_done_cnt", dn, 8);

    src_q.delete(); src_q.push_back('h41);
    run_case(1, 1'b1, 0, lo, dn, gp, ml);
    chk("7e1_41_low_cycles", lo, 112);
    chk("7e1_41_done_cnt", dn, 1);

    src_q.delete(); src_q.push_back('h41);
    run_case(3, 1'b1, 0, lo, dn, gp, ml);
    chk("7o1_41_low_cycles", lo, 96);

    load_random(1, 5);
    run_case(1, 1'b0, 0, lo, dn, gp, ml);
    load_random(3, 5);
    run_case(3, 1'b0, 0, lo, dn, gp, ml);

    src_q.delete(); src_q.push_back('h12); src_q.push_back('h34);
    run_case(2, 1'b1, 0, lo, dn, gp, ml);
    chk("8o2_done_cnt", dn, 2);
    chk("8o2_done_gap", gp, 192);

    load_random(2, 6);
    run_case(2, 1'b0, 0, lo, dn, gp, ml);
    chk("8o2_rand_done_cnt", dn, 6);

    // Abort a frame during data bit 3 with a second byte still queued.
    src_q.delete(); src_q.push_back('hA5); src_q.push_back('h3C);
    run_case(0, 1'b1, 70, lo, dn, gp, ml);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", int'(txw[0]), 1);
    chk("abort_busy", int'(bz[0]), 0);
    chk("abort_level", get_lvl(0), 0);
    chk("abort_ready", int'(rdy[0]), 1);
    chk("abort_done", int'(fd[0]), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    src_q.delete(); src_q.push_back('h55);
    run_case(0, 1'b1, 0, lo, dn, gp, ml);
    chk("after_abort_done_cnt", dn, 1);
    chk("after_abort_low_cycles", lo, 80);

    src_q.delete(); src_q.push_back('hFF);
    run_case(4, 1'b1, 0, lo, dn, gp, ml);
    chk("dflt_ff_low_cycles", lo, 1250);
    chk("dflt_ff_done_cnt", dn, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
